// File: rtl/h14tx_rst_seq_if.sv
// Signal bundle between the HDMI 1.4 TX reset sequencer and its environment.
// lock_loss_cnt exists only when H14TX_RST_SEQ_CNT_EN is defined.
interface h14tx_rst_seq_if;
  logic       lock;
  logic       sw_rst_req;
  logic       ser_rst_n;
  logic       enc_rst_n;
  logic       ctl_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [2:0] state;
`ifdef H14TX_RST_SEQ_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  // PLL/system side: drives lock and soft reset, observes the domain resets.
  modport master (
    output lock, sw_rst_req,
    input  ser_rst_n, enc_rst_n, ctl_rst_n, ready, lock_lost, state
`ifdef H14TX_RST_SEQ_CNT_EN
    , input lock_loss_cnt
`endif
  );

  // Sequencer side.
  modport slave (
    input  lock, sw_rst_req,
    output ser_rst_n, enc_rst_n, ctl_rst_n, ready, lock_lost, state
`ifdef H14TX_RST_SEQ_CNT_EN
    , output lock_loss_cnt
`endif
  );
endinterface

// File: rtl/h14tx_rst_seq.sv
// HDMI 1.4 TX reset sequencer: qualifies PLL lock, releases serializer -> encoder -> control.
// Optional saturating lock-loss counter enabled by H14TX_RST_SEQ_CNT_EN.
module h14tx_rst_seq #(
  parameter int LOCK_CYCLES  = 16,
  parameter int STAGE_CYCLES = 8
) (
  input logic            clk,
  input logic            rst_n,
  h14tx_rst_seq_if.slave bus
);
  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_STABLE = 3'd1;
  localparam logic [2:0] S_SER    = 3'd2;
  localparam logic [2:0] S_ENC    = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  localparam int CNT_MAX = (LOCK_CYCLES > STAGE_CYCLES) ? LOCK_CYCLES : STAGE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);

  logic          sync_q1, lock_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lost_d;
  logic          ser_q, enc_q, ctl_q, ready_q, lost_q;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_q1 <= bus.lock;
      lock_s  <= sync_q1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    lost_d  = 1'b0;
    if (state_q != S_WAIT && (!lock_s || bus.sw_rst_req)) begin
      // Abort: lock loss takes priority for reporting even alongside a soft request.
      state_d = S_WAIT;
      cnt_d   = '0;
      lost_d  = !lock_s;
    end else begin
      case (state_q)
        S_WAIT: begin
          cnt_d = '0;
          if (lock_s) state_d = S_STABLE;
        end
        S_STABLE: if (cnt_q == LOCK_LAST) begin
          state_d = S_SER;
          cnt_d   = '0;
        end
        S_SER: if (cnt_q == STAGE_LAST) begin
          state_d = S_ENC;
          cnt_d   = '0;
        end
        S_ENC: if (cnt_q == STAGE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
        S_RUN: cnt_d = '0;
        default: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      enc_q   <= 1'b0;
      ctl_q   <= 1'b0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ser_q   <= (state_d == S_SER) || (state_d == S_ENC) || (state_d == S_RUN);
      enc_q   <= (state_d == S_ENC) || (state_d == S_RUN);
      ctl_q   <= (state_d == S_RUN);
      ready_q <= (state_d == S_RUN);
      lost_q  <= lost_d;
    end
  end

  assign bus.ser_rst_n = ser_q;
  assign bus.enc_rst_n = enc_q;
  assign bus.ctl_rst_n = ctl_q;
  assign bus.ready     = ready_q;
  assign bus.lock_lost = lost_q;
  assign bus.state     = state_q;

`ifdef H14TX_RST_SEQ_CNT_EN
  logic [7:0] loss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            loss_cnt_q <= 8'd0;
    else if (lost_d && loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`endif
endmodule

// File: tb/tb_h14tx_rst_seq.sv
// Bench for h14tx_rst_seq: directed scenarios plus random lock/soft-reset traffic,
// checked every cycle against a timeline model of the release sequence.
module tb_h14tx_rst_seq;
  localparam int L = 16;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  h14tx_rst_seq_if bus ();
  h14tx_rst_seq #(.LOCK_CYCLES(L), .STAGE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Model: lock synchronizer pipe plus "cycles since qualification began".
  logic m_s1, m_s2, m_lost;
  bit   m_seq;
  int   m_t, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_state();
    if (!m_seq)           return 0;
    if (m_t < L)          return 1;
    if (m_t < L + S)      return 2;
    if (m_t < L + 2 * S)  return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lost = 0; m_seq = 0; m_t = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic lk, input logic sw);
    logic ls;
    ls = m_s2;
    if (!m_seq) begin
      m_lost = 0;
      if (ls) begin m_seq = 1; m_t = 0; end
    end else if (!ls || sw) begin
      m_lost = !ls;
      m_seq  = 0;
      if (!ls && m_cnt < 255) m_cnt++;
    end else begin
      m_lost = 0;
      m_t++;
    end
    m_s2 = m_s1;
    m_s1 = lk;
  endtask

  task automatic compare_all();
    int st;
    st = exp_state();
    check("state",     32'(bus.state),     32'(st));
    check("ser_rst_n", 32'(bus.ser_rst_n), 32'(st >= 2));
    check("enc_rst_n", 32'(bus.enc_rst_n), 32'(st >= 3));
    check("ctl_rst_n", 32'(bus.ctl_rst_n), 32'(st == 4));
    check("ready",     32'(bus.ready),     32'(st == 4));
    check("lock_lost", 32'(bus.lock_lost), 32'(m_lost));
    check("order", 32'((bus.ctl_rst_n & ~bus.enc_rst_n) | (bus.enc_rst_n & ~bus.ser_rst_n)), 32'd0);
`ifdef H14TX_RST_SEQ_CNT_EN
    check("loss_cnt",  32'(bus.lock_loss_cnt), 32'(m_cnt));
`endif
  endtask

  // Inputs change at the negedge; outputs are compared at the following negedge.
  task automatic step(input logic lk, input logic sw);
    bus.lock       = lk;
    bus.sw_rst_req = sw;
    @(posedge clk);
    model_edge(lk, sw);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_until(input int target, input int max_cycles);
    int n;
    n = 0;
    while (exp_state() != target && n < max_cycles) begin
      step(1'b1, 1'b0);
      n++;
    end
    check("run_until_bound", 32'(exp_state()), 32'(target));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.lock = 1'b0;
    bus.sw_rst_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int first_ser, first_enc, first_ctl;
    rst_n = 1'b0;
    bus.lock = 1'b0;
    bus.sw_rst_req = 1'b0;
    do_reset();

    // Release latency with lock high from edge 1.
    first_ser = 0; first_enc = 0; first_ctl = 0;
    for (int e = 1; e <= 40; e++) begin
      step(1'b1, 1'b0);
      if (bus.ser_rst_n && first_ser == 0) first_ser = e;
      if (bus.enc_rst_n && first_enc == 0) first_enc = e;
      if (bus.ctl_rst_n && bus.ready && first_ctl == 0) first_ctl = e;
    end
    check("lat_ser", 32'(first_ser), 32'd19);
    check("lat_enc", 32'(first_enc), 32'd27);
    check("lat_ctl", 32'(first_ctl), 32'd35);

    // One-cycle lock drop in S_RUN, then resequence.
    step(1'b0, 1'b0);
    repeat (45) step(1'b1, 1'b0);
    check("resequenced", 32'(bus.ready), 32'd1);

    // Lock glitch during qualification at cnt=10.
    step(1'b0, 1'b0);
    run_until(1, 10);
    while (exp_state() == 1 && m_t < 10) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0);

    // Soft reset in S_ENC, and in S_WAIT.
    run_until(3, 60);
    step(1'b1, 1'b1);
    check("sw_abort_state", 32'(bus.state), 32'd0);
    check("sw_no_lost", 32'(bus.lock_lost), 32'd0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    run_until(4, 60);

    // Asynchronous reset mid-S_SER.
    step(1'b0, 1'b0);
    run_until(2, 60);
    repeat (3) step(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    do_reset();
    run_until(4, 60);

    // Random lock loss / soft reset traffic.
    for (int i = 0; i < 4000; i++) begin
      logic lk, sw;
      lk = ($urandom_range(0, 59) != 0);
      sw = ($urandom_range(0, 99) == 0);
      step(lk, sw);
    end

`ifdef H14TX_RST_SEQ_CNT_EN
    do_reset();
    for (int k = 0; k < 300; k++) begin
      run_until(4, 60);
      step(1'b0, 1'b0);
    end
    repeat (4) step(1'b1, 1'b0);
    check("cnt_saturated", 32'(bus.lock_loss_cnt), 32'd255);
    do_reset();
    check("cnt_cleared", 32'(bus.lock_loss_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
